// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// with a handshaked memory port and a fixed-latency multiply/divide wait state.
module multicycle_control #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] DMop,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       HiLoSel,
    output logic       ALUSrc,
    output logic [2:0] ALU_Control,
    output logic       EXTop,
    output logic       ToHigh_16,
    output logic       md_start,
    output logic       md_op,
    output logic       HiLoWrite,
    output logic       busy,
    output logic       illegal,
    output logic [2:0] state
);

    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
        $error("multicycle_control: MULT_CYCLES must lie in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("multicycle_control: DIV_CYCLES must lie in 1..15");
    end

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        K_ALU, K_LOAD, K_STORE, K_BEQ, K_JUMP, K_JAL, K_JR, K_JALR,
        K_MULT, K_DIV, K_MFHI, K_MFLO, K_BAD
    } kind_t;

    state_t     cur_state, next_state;
    logic [3:0] md_count, md_count_next;

    kind_t      kind;
    logic       r_type;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       ext_op;
    logic       to_high;
    logic [1:0] dm_width;

    // Instruction classification; only consumed from DECODE onward, so IR contents during FETCH never matter.
    always_comb begin
        kind     = K_BAD;
        r_type   = (opcode == OP_RTYPE);
        alu_ctrl = ALU_AND;
        alu_src  = 1'b0;
        ext_op   = 1'b0;
        to_high  = 1'b0;
        dm_width = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: begin kind = K_ALU; alu_ctrl = ALU_ADD; ext_op = 1'b1; end
                    FN_SUB, FN_SUBU: begin kind = K_ALU; alu_ctrl = ALU_SUB; ext_op = 1'b1; end
                    FN_AND:  begin kind = K_ALU; alu_ctrl = ALU_AND; ext_op = 1'b1; end
                    FN_OR:   begin kind = K_ALU; alu_ctrl = ALU_OR;  ext_op = 1'b1; end
                    FN_JR:   kind = K_JR;
                    FN_JALR: kind = K_JALR;
                    FN_MULT: kind = K_MULT;
                    FN_DIV:  kind = K_DIV;
                    FN_MFHI: kind = K_MFHI;
                    FN_MFLO: kind = K_MFLO;
                    default: kind = K_BAD;
                endcase
            end
            OP_ORI:  begin kind = K_ALU; alu_ctrl = ALU_OR;  alu_src = 1'b1; end
            OP_ADDI: begin kind = K_ALU; alu_ctrl = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
            OP_LUI: begin
                kind     = K_ALU;
                alu_ctrl = ALU_OR;
                alu_src  = 1'b1;
                ext_op   = 1'b1;
                to_high  = 1'b1;
            end
            OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB: begin
                kind     = opcode[3] ? K_STORE : K_LOAD;
                alu_ctrl = ALU_ADD;
                alu_src  = 1'b1;
                ext_op   = 1'b1;
                case (opcode[1:0])
                    2'b00:   dm_width = 2'b01;
                    2'b01:   dm_width = 2'b10;
                    default: dm_width = 2'b00;
                endcase
            end
            OP_BEQ: begin kind = K_BEQ; alu_ctrl = ALU_SUB; end
            OP_J:    kind = K_JUMP;
            OP_JAL:  kind = K_JAL;
            default: kind = K_BAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_FETCH;
            md_count  <= 4'd0;
        end else begin
            cur_state <= next_state;
            md_count  <= md_count_next;
        end
    end

    // Outputs are forced quiet while reset is held so no strobe can fire during an abort.
    always_comb begin
        next_state    = cur_state;
        md_count_next = md_count;
        PCWrite       = 1'b0;
        PCSrc         = 2'b00;
        IRWrite       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        DMop          = 2'b00;
        RegWrite      = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        HiLoSel       = 1'b0;
        ALUSrc        = 1'b0;
        ALU_Control   = 3'b000;
        EXTop         = 1'b0;
        ToHigh_16     = 1'b0;
        md_start      = 1'b0;
        md_op         = 1'b0;
        HiLoWrite     = 1'b0;
        busy          = 1'b0;
        illegal       = 1'b0;
        if (reset) begin
            case (cur_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (kind == K_BAD) begin
                        illegal    = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (kind)
                        K_ALU, K_LOAD, K_STORE: begin
                            ALU_Control = alu_ctrl;
                            ALUSrc      = alu_src;
                            EXTop       = ext_op;
                            ToHigh_16   = to_high;
                            next_state  = (kind == K_ALU) ? S_WB : S_MEM;
                        end
                        K_BEQ: begin
                            ALU_Control = alu_ctrl;
                            PCWrite     = zero;
                            PCSrc       = 2'b01;
                            next_state  = S_FETCH;
                        end
                        K_JUMP, K_JAL: begin
                            PCWrite    = 1'b1;
                            PCSrc      = 2'b10;
                            next_state = S_FETCH;
                            if (kind == K_JAL) begin
                                RegWrite = 1'b1;
                                RegDst   = 2'b10;
                                MemtoReg = 2'b10;
                            end
                        end
                        K_JR, K_JALR: begin
                            PCWrite    = 1'b1;
                            PCSrc      = 2'b11;
                            next_state = S_FETCH;
                            if (kind == K_JALR) begin
                                RegWrite = 1'b1;
                                RegDst   = 2'b01;
                                MemtoReg = 2'b10;
                            end
                        end
                        K_MULT, K_DIV: begin
                            md_start      = 1'b1;
                            md_op         = (kind == K_DIV);
                            md_count_next = (kind == K_DIV) ? DIV_LOAD : MULT_LOAD;
                            next_state    = S_MDU_WAIT;
                        end
                        K_MFHI, K_MFLO: begin
                            HiLoSel    = (kind == K_MFHI);
                            next_state = S_WB;
                        end
                        default: next_state = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    DMop     = dm_width;
                    MemRead  = (kind == K_LOAD);
                    MemWrite = (kind == K_STORE);
                    if (mem_ready) begin
                        next_state = (kind == K_LOAD) ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = r_type ? 2'b01 : 2'b00;
                    HiLoSel    = (kind == K_MFHI);
                    next_state = S_FETCH;
                    if (kind == K_LOAD) begin
                        MemtoReg = 2'b01;
                    end else if (kind == K_MFHI || kind == K_MFLO) begin
                        MemtoReg = 2'b11;
                    end
                end
                S_MDU_WAIT: begin
                    // Counter is loaded with the occupancy, so the cycle seeing 1 is the last one.
                    busy = 1'b1;
                    if (md_count <= 4'd1) begin
                        HiLoWrite     = 1'b1;
                        md_count_next = 4'd0;
                        next_state    = S_FETCH;
                    end else begin
                        md_count_next = md_count - 4'd1;
                    end
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected per-cycle output vectors are queued
// as stimulus is applied and checked at the following falling clock edge.
module tb_multicycle_control;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 3;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_DEC   = 3'd1;
    localparam logic [2:0] ST_EXE   = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_MDU   = 3'd5;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] NOFN = 6'b000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, HiLoSel, ALUSrc, EXTop, ToHigh_16;
    logic       md_start, md_op, HiLoWrite, busy, illegal;
    logic [1:0] PCSrc, DMop, RegDst, MemtoReg;
    logic [2:0] ALU_Control, state;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       irw, mrd, mwr;
        logic [1:0] dmop;
        logic       rw;
        logic [1:0] rdst, m2r;
        logic       hls, alusrc;
        logic [2:0] aluc;
        logic       ext, toh, mds, mdop, hlw, bsy, ill;
    } out_t;

    typedef struct {
        string tag;
        out_t  exp;
    } sb_t;

    out_t obs;
    sb_t  sb[$];
    int   checks = 0;
    int   passes = 0;

    multicycle_control #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .DMop(DMop), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .HiLoSel(HiLoSel),
        .ALUSrc(ALUSrc), .ALU_Control(ALU_Control), .EXTop(EXTop), .ToHigh_16(ToHigh_16),
        .md_start(md_start), .md_op(md_op), .HiLoWrite(HiLoWrite), .busy(busy), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, DMop, RegWrite, RegDst, MemtoReg,
                  HiLoSel, ALUSrc, ALU_Control, EXTop, ToHigh_16, md_start, md_op, HiLoWrite, busy, illegal};

    task automatic check_output(input string tag, input out_t exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t item;
            item = sb.pop_front();
            check_output(item.tag, item.exp);
        end
    end

    function automatic out_t at(input logic [2:0] s);
        out_t r;
        r    = '0;
        r.st = s;
        return r;
    endfunction

    function automatic out_t fetch_exp(input logic rdy);
        out_t r;
        r     = at(ST_FETCH);
        r.mrd = 1'b1;
        r.irw = rdy;
        r.pcw = rdy;
        return r;
    endfunction

    // Called just after a rising edge; the expectation is checked at the next falling edge.
    task automatic apply_stimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                  input logic zr, input logic rdy, input out_t exp);
        sb_t item;
        opcode    = op;
        funct     = fn;
        zero      = zr;
        mem_ready = rdy;
        item.tag  = tag;
        item.exp  = exp;
        sb.push_back(item);
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_t e;
        reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        check_output("reset_state", '0);
        @(posedge clk); #1;
        reset = 1'b1;

        apply_stimulus("addu_fetch_garbage_ir", 6'h3f, 6'h3f, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("addu_decode", R, 6'b100001, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.aluc = 3'b010; e.ext = 1'b1;
        apply_stimulus("addu_exec", R, 6'b100001, 1'b0, 1'b1, e);
        e = at(ST_WB); e.rw = 1'b1; e.rdst = 2'b01;
        apply_stimulus("addu_wb", R, 6'b100001, 1'b0, 1'b1, e);

        apply_stimulus("lw_fetch_stall0", 6'b100011, NOFN, 1'b0, 1'b0, fetch_exp(1'b0));
        apply_stimulus("lw_fetch_stall1", 6'b100011, NOFN, 1'b0, 1'b0, fetch_exp(1'b0));
        apply_stimulus("lw_fetch", 6'b100011, NOFN, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("lw_decode", 6'b100011, NOFN, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.aluc = 3'b010; e.alusrc = 1'b1; e.ext = 1'b1;
        apply_stimulus("lw_exec", 6'b100011, NOFN, 1'b0, 1'b1, e);
        e = at(ST_MEM); e.mrd = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus("lw_mem_stall", 6'b100011, NOFN, 1'b0, 1'b0, e);
        apply_stimulus("lw_mem_ready", 6'b100011, NOFN, 1'b0, 1'b1, e);
        e = at(ST_WB); e.rw = 1'b1; e.m2r = 2'b01;
        apply_stimulus("lw_wb", 6'b100011, NOFN, 1'b0, 1'b1, e);

        apply_stimulus("sh_fetch", 6'b101001, NOFN, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("sh_decode", 6'b101001, NOFN, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.aluc = 3'b010; e.alusrc = 1'b1; e.ext = 1'b1;
        apply_stimulus("sh_exec", 6'b101001, NOFN, 1'b0, 1'b1, e);
        e = at(ST_MEM); e.mwr = 1'b1; e.dmop = 2'b10;
        apply_stimulus("sh_mem_stall", 6'b101001, NOFN, 1'b0, 1'b0, e);
        apply_stimulus("sh_mem_ready", 6'b101001, NOFN, 1'b0, 1'b1, e);

        for (int z = 1; z >= 0; z--) begin
            apply_stimulus("beq_fetch", 6'b000100, NOFN, 1'(z), 1'b1, fetch_exp(1'b1));
            apply_stimulus("beq_decode", 6'b000100, NOFN, 1'(z), 1'b1, at(ST_DEC));
            e = at(ST_EXE); e.aluc = 3'b110; e.pcw = 1'(z); e.pcsrc = 2'b01;
            apply_stimulus("beq_exec", 6'b000100, NOFN, 1'(z), 1'b1, e);
        end

        apply_stimulus("mult_fetch", R, 6'b011000, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("mult_decode", R, 6'b011000, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.mds = 1'b1;
        apply_stimulus("mult_exec", R, 6'b011000, 1'b0, 1'b1, e);
        for (int i = 1; i <= MULT_N; i++) begin
            e = at(ST_MDU); e.bsy = 1'b1; e.hlw = (i == MULT_N);
            apply_stimulus("mult_wait", R, 6'b011000, 1'b0, 1'b1, e);
        end
        apply_stimulus("mflo_fetch", R, 6'b010010, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("mflo_decode", R, 6'b010010, 1'b0, 1'b1, at(ST_DEC));
        apply_stimulus("mflo_exec", R, 6'b010010, 1'b0, 1'b1, at(ST_EXE));
        e = at(ST_WB); e.rw = 1'b1; e.rdst = 2'b01; e.m2r = 2'b11;
        apply_stimulus("mflo_wb", R, 6'b010010, 1'b0, 1'b1, e);

        apply_stimulus("div_fetch", R, 6'b011010, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("div_decode", R, 6'b011010, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.mds = 1'b1; e.mdop = 1'b1;
        apply_stimulus("div_exec", R, 6'b011010, 1'b0, 1'b1, e);
        for (int i = 1; i <= DIV_N; i++) begin
            e = at(ST_MDU); e.bsy = 1'b1; e.hlw = (i == DIV_N);
            apply_stimulus("div_wait", R, 6'b011010, 1'b0, 1'b1, e);
        end
        apply_stimulus("mfhi_fetch", R, 6'b010000, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("mfhi_decode", R, 6'b010000, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.hls = 1'b1;
        apply_stimulus("mfhi_exec", R, 6'b010000, 1'b0, 1'b1, e);
        e = at(ST_WB); e.rw = 1'b1; e.rdst = 2'b01; e.m2r = 2'b11; e.hls = 1'b1;
        apply_stimulus("mfhi_wb", R, 6'b010000, 1'b0, 1'b1, e);

        apply_stimulus("jal_fetch", 6'b000011, NOFN, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("jal_decode", 6'b000011, NOFN, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.pcw = 1'b1; e.pcsrc = 2'b10; e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10;
        apply_stimulus("jal_exec", 6'b000011, NOFN, 1'b0, 1'b1, e);

        apply_stimulus("jalr_fetch", R, 6'b001001, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("jalr_decode", R, 6'b001001, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.pcw = 1'b1; e.pcsrc = 2'b11; e.rw = 1'b1; e.rdst = 2'b01; e.m2r = 2'b10;
        apply_stimulus("jalr_exec", R, 6'b001001, 1'b0, 1'b1, e);

        apply_stimulus("lui_fetch", 6'b001111, NOFN, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("lui_decode", 6'b001111, NOFN, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.aluc = 3'b001; e.alusrc = 1'b1; e.ext = 1'b1; e.toh = 1'b1;
        apply_stimulus("lui_exec", 6'b001111, NOFN, 1'b0, 1'b1, e);
        e = at(ST_WB); e.rw = 1'b1;
        apply_stimulus("lui_wb", 6'b001111, NOFN, 1'b0, 1'b1, e);

        apply_stimulus("ori_fetch", 6'b001101, NOFN, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("ori_decode", 6'b001101, NOFN, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.aluc = 3'b001; e.alusrc = 1'b1;
        apply_stimulus("ori_exec", 6'b001101, NOFN, 1'b0, 1'b1, e);
        e = at(ST_WB); e.rw = 1'b1;
        apply_stimulus("ori_wb", 6'b001101, NOFN, 1'b0, 1'b1, e);

        apply_stimulus("bad_fetch", 6'b111111, NOFN, 1'b0, 1'b1, fetch_exp(1'b1));
        e = at(ST_DEC); e.ill = 1'b1;
        apply_stimulus("bad_decode", 6'b111111, NOFN, 1'b0, 1'b1, e);

        apply_stimulus("rst_addu_fetch", R, 6'b100001, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("rst_addu_decode", R, 6'b100001, 1'b0, 1'b1, at(ST_DEC));
        e = at(ST_EXE); e.aluc = 3'b010; e.ext = 1'b1;
        #1 check_output("rst_addu_exec", e);
        #1 reset = 1'b0;
        #1 check_output("reset_async_mid_exec", '0);
        @(posedge clk); #1;
        reset = 1'b1;
        apply_stimulus("post_reset_fetch_wait", R, 6'b100001, 1'b0, 1'b0, fetch_exp(1'b0));
        apply_stimulus("post_reset_fetch", R, 6'b100001, 1'b0, 1'b1, fetch_exp(1'b1));
        apply_stimulus("post_reset_decode", R, 6'b100001, 1'b0, 1'b1, at(ST_DEC));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
